instr_sequencer: RTL

//  Autonomous instruction issuer for the matrix coprocessor ("top").
//  - Holds a small program of INSTR_W-bit coprocessor instructions in a RAM.
//  - On go, issues the program to the coprocessor one instruction at a time over a valid/ready handshake.
//  - Waits for cop_done after each instruction; continuous or single-step modes; stops at a HALT opcode.
//  - Replaces manual button-stepping of instruction words; sits between the debounced board inputs and the coprocessor.

---
 rtl/cop_pkg.sv | 26 ++
 rtl/instr_sequencer_if.sv | 13 +
 rtl/instr_prog_ram.sv | 24 ++
 rtl/instr_sequencer.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/cop_pkg.sv
// Shared types and constants for the matrix coprocessor instruction sequencer.
package cop_pkg;

    localparam int unsigned INSTR_W  = 22;
    localparam int unsigned OPCODE_W = 4;

    localparam logic [OPCODE_W-1:0] OP_HALT  = 4'h0;
    localparam logic [OPCODE_W-1:0] OP_STORE = 4'h2;
    localparam logic [OPCODE_W-1:0] OP_SUM   = 4'h3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_ISSUE,
        ST_WAIT_DONE,
        ST_PAUSE,
        ST_HALTED,
        ST_ERROR
    } seq_state_e;

    function automatic logic [OPCODE_W-1:0] opcode_of(input logic [INSTR_W-1:0] instr);
        return instr[OPCODE_W-1:0];
    endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// Valid/ready instruction channel plus completion pulse towards the coprocessor.
interface instr_sequencer_if;
    import cop_pkg::*;

    logic [INSTR_W-1:0] cop_instr;
    logic               cop_valid;
    logic               cop_ready;
    logic               cop_done;

    modport master (output cop_instr, cop_valid, input  cop_ready, cop_done);
    modport slave  (input  cop_instr, cop_valid, output cop_ready, cop_done);

endinterface

// File: rtl/instr_prog_ram.sv
// Program store: one write port, one synchronous read port with 1-cycle latency.
module instr_prog_ram #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 22
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/instr_sequencer.sv
// Issues a stored program to the coprocessor one instruction at a time,
// waiting for completion after each, with single-step, halt and timeout handling.
module instr_sequencer
    import cop_pkg::*;
#(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned ADDR_W  = $clog2(DEPTH),
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                go,
    input  logic                step,
    input  logic                step_mode,
    input  logic                abort,
    input  logic                prog_we,
    input  logic [ADDR_W-1:0]   prog_addr,
    input  logic [INSTR_W-1:0]  prog_data,
    instr_sequencer_if.master   bus,
    output logic [ADDR_W-1:0]   pc,
    output logic                busy,
    output logic                halted,
    output logic                err
);

    localparam int unsigned TIMER_W = $clog2(TIMEOUT);

    seq_state_e          state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [INSTR_W-1:0]  instr_q, instr_d;
    logic                valid_q, valid_d;
    logic                busy_q, busy_d;
    logic                halted_q, halted_d;
    logic                err_q, err_d;
    logic [TIMER_W-1:0]  timer_q, timer_d;
    logic                go_q, go_rise_q, step_q;
    logic                step_rise_c;
    logic [INSTR_W-1:0]  rd_data;

    // The program may only be rewritten while no run is in progress.
    instr_prog_ram #(
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W),
        .DATA_W(INSTR_W)
    ) u_ram (
        .clk  (clk),
        .we   (prog_we && !busy_q),
        .waddr(prog_addr),
        .wdata(prog_data),
        .raddr(pc_q),
        .rdata(rd_data)
    );

    assign step_rise_c = step && !step_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            pc_q      <= '0;
            instr_q   <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            halted_q  <= 1'b0;
            err_q     <= 1'b0;
            timer_q   <= '0;
            go_q      <= 1'b0;
            go_rise_q <= 1'b0;
            step_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            halted_q  <= halted_d;
            err_q     <= err_d;
            timer_q   <= timer_d;
            go_q      <= go;
            go_rise_q <= go && !go_q;
            step_q    <= step;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        valid_d  = valid_q;
        halted_d = halted_q;
        err_d    = err_q;
        timer_d  = timer_q;

        if (abort) begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_HALTED, ST_ERROR: begin
                    if (go_rise_q) begin
                        pc_d     = '0;
                        err_d    = 1'b0;
                        halted_d = 1'b0;
                        state_d  = ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    state_d = ST_DECODE;
                end
                ST_DECODE: begin
                    if (opcode_of(rd_data) == OP_HALT) begin
                        halted_d = 1'b1;
                        state_d  = ST_HALTED;
                    end else begin
                        instr_d = rd_data;
                        valid_d = 1'b1;
                        state_d = ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (bus.cop_ready) begin
                        valid_d = 1'b0;
                        timer_d = '0;
                        state_d = ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    // Completion wins over a timeout landing on the same cycle.
                    if (bus.cop_done) begin
                        if (pc_q == ADDR_W'(DEPTH - 1)) begin
                            halted_d = 1'b1;
                            state_d  = ST_HALTED;
                        end else begin
                            pc_d    = pc_q + ADDR_W'(1);
                            state_d = step_mode ? ST_PAUSE : ST_FETCH;
                        end
                    end else if (timer_q == TIMER_W'(TIMEOUT - 1)) begin
                        err_d   = 1'b1;
                        state_d = ST_ERROR;
                    end else begin
                        timer_d = timer_q + TIMER_W'(1);
                    end
                end
                ST_PAUSE: begin
                    if (step_rise_c || !step_mode) begin
                        state_d = ST_FETCH;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        busy_d = !(state_d inside {ST_IDLE, ST_HALTED, ST_ERROR});
    end

    assign bus.cop_instr = instr_q;
    assign bus.cop_valid = valid_q;
    assign pc            = pc_q;
    assign busy          = busy_q;
    assign halted        = halted_q;
    assign err           = err_q;

endmodule
